// File: rtl/fg_responder_pkg.sv
// fg_responder_pkg
// Shared types for the foreground SRAM responder:
//   pixel_t        16-bit RGB565 pixel
//   tag_t          per-request tag that travels alongside the SRAM read latency
//   TAG_SKIP       tag value meaning "no pixel for this slot"
//   fg_pixel_addr  linear word address y*width + x
package fg_responder_pkg;

  typedef logic [15:0] pixel_t;

  typedef struct packed {
    logic skip;   // request was inactive or out of bounds
    logic reuse;  // answer from the last pixel returned by the SRAM
  } tag_t;

  localparam tag_t TAG_SKIP = '{skip: 1'b1, reuse: 1'b0};

  function automatic logic [31:0] fg_pixel_addr(input logic [31:0] x,
                                                input logic [31:0] y,
                                                input logic [31:0] width);
    return y * width + x;
  endfunction

endpackage

// File: rtl/fg_tag_delay.sv
// fg_tag_delay
// Fixed-depth shift register for request tags so each tag lines up with the
// SRAM read data of its own request. Synchronous reset fills it with skips.
// Ports:
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   i_tag  tag of the request accepted this cycle
//   o_tag  tag delayed by DEPTH cycles
module fg_tag_delay
  import fg_responder_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_line [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_line[i] <= TAG_SKIP;
    end else begin
      r_line[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
    end
  end

  assign o_tag = r_line[DEPTH-1];

endmodule

// File: rtl/fg_sram_responder.sv
// fg_sram_responder
// Answers one signed foreground coordinate per clock with a 16-bit pixel or a
// skip flag, at a fixed latency of SRAM_LATENCY+2 cycles. Shares the single
// SRAM port with frame-capture writes; pipeline reads always win.
// Optional feature macro: FG_RESPONDER_REPEAT_CACHE_EN -- a request for the
// address of the last issued read reuses that pixel instead of reading again,
// which frees the slot for a write.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   fg_pixel_request_x/_y/_active   pipeline request (signed coordinates)
//   fg_pixel_out, fg_pixel_skip     registered response
//   sram_addr/read/write/wdata      SRAM command port (registered)
//   sram_rdata                      SRAM read data, SRAM_LATENCY after read
//   wr_valid/addr/data, wr_ready    capture write handshake (wr_ready comb.)
module fg_sram_responder
  import fg_responder_pkg::*;
#(
  parameter int PRECISION    = 12,
  parameter int RESOLUTION_X = 1920,
  parameter int RESOLUTION_Y = 1080,
  parameter int ADDR_WIDTH   = 21,
  parameter int SRAM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [PRECISION:0] fg_pixel_request_x,
  input  logic signed [PRECISION:0] fg_pixel_request_y,
  input  logic                    fg_pixel_request_active,
  output pixel_t                  fg_pixel_out,
  output logic                    fg_pixel_skip,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic                    sram_read,
  output logic                    sram_write,
  output pixel_t                  sram_wdata,
  input  pixel_t                  sram_rdata,
  input  logic                    wr_valid,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  pixel_t                  wr_data,
  output logic                    wr_ready
);

  localparam logic signed [PRECISION:0] LP_ZERO  = '0;
  localparam logic signed [PRECISION:0] LP_RES_X = (PRECISION+1)'(RESOLUTION_X);
  localparam logic signed [PRECISION:0] LP_RES_Y = (PRECISION+1)'(RESOLUTION_Y);

  logic                  w_in_bounds;
  logic                  w_hit;
  logic                  w_read_needed;
  logic [ADDR_WIDTH-1:0] w_addr;
  tag_t                  w_tag_in;
  tag_t                  w_tag_out;
  pixel_t                r_last_pix;

  assign w_in_bounds = fg_pixel_request_active &&
                       (fg_pixel_request_x >= LP_ZERO) && (fg_pixel_request_x < LP_RES_X) &&
                       (fg_pixel_request_y >= LP_ZERO) && (fg_pixel_request_y < LP_RES_Y);

  // Only meaningful when in bounds; out-of-bounds values never reach the SRAM.
  assign w_addr = ADDR_WIDTH'(fg_pixel_addr(32'($unsigned(fg_pixel_request_x)),
                                            32'($unsigned(fg_pixel_request_y)),
                                            32'(RESOLUTION_X)));

`ifdef FG_RESPONDER_REPEAT_CACHE_EN
  logic [ADDR_WIDTH-1:0] r_cache_addr;
  logic                  r_cache_valid;

  assign w_hit = w_in_bounds && r_cache_valid && (r_cache_addr == w_addr);

  // Writes can only land in slots with no read, so the two branches never
  // compete; a write to the cached word makes the held pixel stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_addr  <= '0;
      r_cache_valid <= 1'b0;
    end else if (w_read_needed) begin
      r_cache_addr  <= w_addr;
      r_cache_valid <= 1'b1;
    end else if (wr_ready && (wr_addr == r_cache_addr)) begin
      r_cache_valid <= 1'b0;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  assign w_read_needed = w_in_bounds && !w_hit;
  assign wr_ready      = wr_valid && !w_read_needed && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (w_read_needed) begin
      sram_read  <= 1'b1;
      sram_write <= 1'b0;
      sram_addr  <= w_addr;
    end else if (wr_ready) begin
      sram_read  <= 1'b0;
      sram_write <= 1'b1;
      sram_addr  <= wr_addr;
      sram_wdata <= wr_data;
    end else begin
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
    end
  end

  assign w_tag_in.skip  = !w_in_bounds;
  assign w_tag_in.reuse = w_hit;

  // One stage for the command register plus SRAM_LATENCY for the SRAM itself.
  fg_tag_delay #(
    .DEPTH (SRAM_LATENCY + 1)
  ) u_tag_delay (
    .i_clk (clk),
    .i_rst (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Reuse tags always trail the read they repeat, so r_last_pix already
  // holds that read's data when a reuse tag arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      fg_pixel_out  <= '0;
      fg_pixel_skip <= 1'b1;
      r_last_pix    <= '0;
    end else if (w_tag_out.skip) begin
      fg_pixel_out  <= '0;
      fg_pixel_skip <= 1'b1;
    end else if (w_tag_out.reuse) begin
      fg_pixel_out  <= r_last_pix;
      fg_pixel_skip <= 1'b0;
    end else begin
      fg_pixel_out  <= sram_rdata;
      fg_pixel_skip <= 1'b0;
      r_last_pix    <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_fg_sram_responder.sv
// tb_fg_sram_responder
// Scoreboard bench: the stimulus process pushes expected responses and
// expected SRAM commands into queues; a negedge monitor (which also models
// the SRAM) pops and compares them.
module tb_fg_sram_responder;
  localparam int RX = 1920;
  localparam int RY = 1080;
  localparam int L  = 2;
  localparam int AW = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic signed [12:0] req_x = '0, req_y = '0;
  logic               req_act = 1'b0;
  logic [15:0]        pix_out;
  logic               pix_skip;
  logic [AW-1:0]      sram_addr;
  logic               sram_read, sram_write;
  logic [15:0]        sram_wdata;
  logic [15:0]        sram_rdata = '0;
  logic               wr_valid = 1'b0;
  logic [AW-1:0]      wr_addr = '0;
  logic [15:0]        wr_data = '0;
  logic               wr_ready;

  fg_sram_responder dut (
    .clk                     (clk),
    .rst                     (rst),
    .fg_pixel_request_x      (req_x),
    .fg_pixel_request_y      (req_y),
    .fg_pixel_request_active (req_act),
    .fg_pixel_out            (pix_out),
    .fg_pixel_skip           (pix_skip),
    .sram_addr               (sram_addr),
    .sram_read               (sram_read),
    .sram_write              (sram_write),
    .sram_wdata              (sram_wdata),
    .sram_rdata              (sram_rdata),
    .wr_valid                (wr_valid),
    .wr_addr                 (wr_addr),
    .wr_data                 (wr_data),
    .wr_ready                (wr_ready)
  );

  typedef struct { logic skip; logic [15:0] pix; } exp_t;
  typedef struct { bit rd; bit wr; bit rs; int addr; logic [15:0] wdata; } bus_t;

  exp_t        exp_q[$];
  bus_t        bus_q[$];
  int          n_checks = 0, n_pass = 0;
  logic [15:0] ref_mem[int];
  logic [15:0] sram_mem[int];
  logic [15:0] rd_pipe[L];
  int          obs_reads = 0, exp_reads = 0;
  bit          c_v = 1'b0;
  int          c_a = 0;
  int          cyc = 0;
`ifdef FG_RESPONDER_REPEAT_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  function automatic logic [15:0] dflt(int a);
    return 16'(a) ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] ref_rd(int a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] sram_rd(int a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
  endtask

  // Reference model: a request sees memory as it stands when the request is
  // made; the optional repeat cache skips a read when the address equals the
  // last one read and no write has touched it since.
  task automatic step(input bit r, input bit act, input int x, input int y,
                      input bit wv, input int wa, input logic [15:0] wd);
    bit   inb, hit, need, exp_rdy;
    int   a;
    exp_t e;
    bus_t b;
    @(posedge clk);
    #1;
    rst      = r;
    req_act  = act;
    req_x    = 13'(x);
    req_y    = 13'(y);
    wr_valid = wv;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    inb = act && (x >= 0) && (x < RX) && (y >= 0) && (y < RY);
    a   = y * RX + x;
    b   = '{rd: 1'b0, wr: 1'b0, rs: 1'b0, addr: 0, wdata: 16'h0};
    if (r) begin
      for (int k = 1; k <= 3 && k <= exp_q.size(); k++)
        exp_q[exp_q.size()-k] = '{skip: 1'b1, pix: 16'h0};
      e = '{skip: 1'b1, pix: 16'h0};
      b.rs = 1'b1;
      c_v = 1'b0;
      exp_rdy = 1'b0;
    end else begin
      hit  = CACHE && inb && c_v && (c_a == a);
      need = inb && !hit;
      e = inb ? '{skip: 1'b0, pix: ref_rd(a)} : '{skip: 1'b1, pix: 16'h0};
      exp_rdy = wv && !need;
      if (need) begin
        b.rd = 1'b1; b.addr = a;
        c_a = a; c_v = 1'b1;
        exp_reads++;
      end else if (exp_rdy) begin
        b.wr = 1'b1; b.addr = wa; b.wdata = wd;
        ref_mem[wa] = wd;
        if (c_v && c_a == wa) c_v = 1'b0;
      end
    end
    exp_q.push_back(e);
    bus_q.push_back(b);
    #1;
    if (wv) check("wr_ready", wr_ready, exp_rdy);
  endtask

  task automatic req(input int x, input int y);
    step(1'b0, 1'b1, x, y, 1'b0, 0, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, 16'h0);
  endtask

  task automatic preset(input int a, input logic [15:0] d);
    ref_mem[a]  = d;
    sram_mem[a] = d;
  endtask

  function automatic int pick(input int max);
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 7));
      1:       return int'($urandom_range(0, max - 1));
      2:       return max - 1 + int'($urandom_range(0, 2));
      default: return -int'($urandom_range(1, 3));
    endcase
  endfunction

  // Monitor + SRAM model. Command seen in cycle c returns data sampled at the
  // end of cycle c+L.
  always @(negedge clk) begin
    bus_t b;
    exp_t e;
    if (sram_write === 1'b1) sram_mem[int'(sram_addr)] = sram_wdata;
    sram_rdata = rd_pipe[L-1];
    for (int i = L - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
    rd_pipe[0] = (sram_read === 1'b1) ? sram_rd(int'(sram_addr)) : 16'($urandom);
    if (sram_read === 1'b1) obs_reads++;
    if (cyc >= 1) begin
      check("rd_wr_exclusive", {31'b0, sram_read & sram_write}, 32'd0);
      if (bus_q.size() > 0) begin
        b = bus_q.pop_front();
        if (b.rs) begin
          check("rst_sram_cmd", {sram_read, sram_write}, 32'd0);
          check("rst_sram_addr", sram_addr, 32'd0);
          check("rst_sram_wdata", sram_wdata, 32'd0);
        end else begin
          check("sram_read", sram_read, b.rd);
          check("sram_write", sram_write, b.wr);
          if (b.rd || b.wr) check("sram_addr", sram_addr, b.addr);
          if (b.wr) check("sram_wdata", sram_wdata, b.wdata);
        end
      end
    end
    if (cyc >= 4) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fg_pixel_skip", pix_skip, e.skip);
        check("fg_pixel_out", pix_out, e.pix);
      end else begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end
    end
    cyc++;
  end

  initial begin
    for (int i = 0; i < L; i++) rd_pipe[i] = 16'h0;
    preset(0, 16'h1111);
    preset(1, 16'h2222);
    preset(RY * RX - 1, 16'h3333);
    preset(5 * RX + 5, 16'hABCD);
    preset(5 * RX + 6, 16'h1234);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 0, 16'h0);
    idle(2);

    // in-bounds sequence
    req(0, 0); req(1, 0); req(RX - 1, RY - 1);
    idle(5);

    // bounds: negative, x edge, y edge, inactive in-range coordinate
    req(-1, 0); req(RX, 5); req(0, RY);
    step(1'b0, 1'b0, 10, 10, 1'b0, 0, 16'h0);
    idle(5);

    // arbitration: write held across three reads, lands in first idle slot
    step(1'b0, 1'b1, 10, 1, 1'b1, 100, 16'hBEEF);
    step(1'b0, 1'b1, 11, 1, 1'b1, 100, 16'hBEEF);
    step(1'b0, 1'b1, 12, 1, 1'b1, 100, 16'hBEEF);
    step(1'b0, 1'b0, 0, 0, 1'b1, 100, 16'hBEEF);
    idle(1);
    req(100, 0);
    idle(5);

    // reset while three reads are in flight
    req(20, 2); req(21, 2); req(22, 2);
    step(1'b1, 1'b1, 23, 2, 1'b0, 0, 16'h0);
    idle(4);
    req(24, 2);
    idle(5);

    // repeat requests, then invalidation by a write to the cached word
    req(5, 5); req(5, 5); req(6, 5);
    idle(5);
    req(5, 5);
    idle(1);
    step(1'b0, 1'b0, 0, 0, 1'b1, 5 * RX + 5, 16'h7777);
    idle(1);
    req(5, 5);
    idle(5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
           pick(RX), pick(RY), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 7)) + 5 * RX,
           16'($urandom));
    end
    idle(8);
    check("read_count", obs_reads, exp_reads);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
